// File: rtl/alu_pkg.sv
// Shared widths, opcode encoding and the command record for the ALU command queue.
package alu_pkg;

  localparam int AW = 4;  // operand width
  localparam int OW = 2;  // opcode width
  localparam int YW = 8;  // result width

  // Opcode meaning is only interpreted by the ALU and the bench; the queue
  // carries the field untouched.
  typedef enum logic [OW-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_AND = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [OW-1:0] op;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Bus bundle for the ALU command queue: upstream command handshake, ALU
// operand/result wiring and downstream result handshake plus status.
interface alu_cmd_queue_if import alu_pkg::*; #(
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_a;
  logic [AW-1:0] in_b;
  logic [OW-1:0] in_op;

  logic [AW-1:0] alu_a;
  logic [AW-1:0] alu_b;
  logic [OW-1:0] alu_op;
  logic [YW-1:0] alu_y;

  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_a;
  logic [AW-1:0] out_b;
  logic [OW-1:0] out_op;
  logic [YW-1:0] out_y;

  logic [CW-1:0] count;
  logic [15:0]   res_cnt;

  // The queue itself.
  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_op,
    output out_valid, out_a, out_b, out_op, out_y, count, res_cnt
  );

  // The environment around the queue: producer, ALU and consumer.
  modport master (
    output in_valid, in_a, in_b, in_op, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_op,
    input  out_valid, out_a, out_b, out_op, out_y, count, res_cnt
  );

endinterface

// File: rtl/cmd_fifo.sv
// First-word-fall-through FIFO of ALU commands. The head is read
// asynchronously so a command pushed on one edge is visible right after it.
module cmd_fifo import alu_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  alu_cmd_t      i_data,
  input  logic          i_pop,
  output alu_cmd_t      o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  alu_cmd_t      r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/alu_cmd_queue.sv
// Flow-controlled wrapper around a combinational ALU: commands queue in a
// FIFO, the head drives the ALU, and the result is captured in a
// back-pressurable output register.
module alu_cmd_queue import alu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  alu_cmd_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  alu_cmd_t      w_in_cmd;
  alu_cmd_t      w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_load;
  logic          w_deliver;

  logic          r_out_valid;
  logic [AW-1:0] r_out_a;
  logic [AW-1:0] r_out_b;
  logic [OW-1:0] r_out_op;
  logic [YW-1:0] r_out_y;
  logic [15:0]   r_res_cnt;

  assign w_in_cmd  = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
  assign w_deliver = r_out_valid & bus.out_ready;
  // Capture whenever a command is waiting and the output slot is free or freeing.
  assign w_load    = ~w_empty & (~r_out_valid | bus.out_ready);

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.in_valid),
    .i_data  (w_in_cmd),
    .i_pop   (w_load),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ALU operands come only from FIFO storage, zeroed when nothing is queued.
  assign bus.alu_a  = w_empty ? '0 : w_head.a;
  assign bus.alu_b  = w_empty ? '0 : w_head.b;
  assign bus.alu_op = w_empty ? '0 : w_head.op;

  // Output register: load the head with its ALU result, otherwise hold fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_op    <= '0;
      r_out_y     <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_head.a;
      r_out_b     <= w_head.b;
      r_out_op    <= w_head.op;
      r_out_y     <= bus.alu_y;
    end else if (w_deliver) begin
      r_out_valid <= 1'b0;
    end
  end

  // Delivered-result counter, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_res_cnt <= '0;
    else if (w_deliver) r_res_cnt <= r_res_cnt + 16'd1;
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_op    = r_out_op;
  assign bus.out_y     = r_out_y;
  assign bus.count     = w_count;
  assign bus.res_cnt   = r_res_cnt;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed plus randomized bench for alu_cmd_queue, checked against a
// queue-based transaction model and an external reference ALU.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, wired externally as in the integration top.
  function automatic logic [YW-1:0] alu_ref(logic [AW-1:0] a, logic [AW-1:0] b, logic [OW-1:0] op);
    case (op)
      2'd0:    return {4'b0, a} + {4'b0, b};
      2'd1:    return {4'b0, a} - {4'b0, b};
      2'd2:    return {4'b0, a} * {4'b0, b};
      default: return {4'b0, a & b};
    endcase
  endfunction

  assign bus.alu_y = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

  // Transaction-level model state.
  alu_cmd_t       m_q[$];
  logic           m_valid;
  alu_cmd_t       m_out;
  logic [YW-1:0]  m_y;
  logic [15:0]    m_res;
  logic           m_last_push;
  logic [YW-1:0]  delivered[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid     = 1'b0;
    m_out       = '0;
    m_y         = '0;
    m_res       = '0;
    m_last_push = 1'b0;
  endtask

  // One clock edge of the model using the inputs present at that edge.
  task automatic model_edge();
    logic     push, load, deliver;
    alu_cmd_t c;
    push    = bus.in_valid && (m_q.size() < DEPTH);
    load    = (m_q.size() > 0) && (!m_valid || bus.out_ready);
    deliver = m_valid && bus.out_ready;
    c       = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
    if (deliver) begin
      m_res = m_res + 16'd1;
      delivered.push_back(m_y);
      $display("deliver #%0d a=%0d b=%0d op=%0d y=%0d", m_res, m_out.a, m_out.b, m_out.op, m_y);
    end
    if (load) begin
      m_out   = m_q.pop_front();
      m_y     = alu_ref(m_out.a, m_out.b, m_out.op);
      m_valid = 1'b1;
    end else if (deliver) begin
      m_valid = 1'b0;
    end
    if (push) m_q.push_back(c);
    m_last_push = push;
  endtask

  task automatic check_all(string tag);
    alu_cmd_t h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(m_q.size() < DEPTH));
    chk({tag, ".count"},     32'(bus.count),     32'(m_q.size()));
    chk({tag, ".alu_a"},     32'(bus.alu_a),     32'(h.a));
    chk({tag, ".alu_b"},     32'(bus.alu_b),     32'(h.b));
    chk({tag, ".alu_op"},    32'(bus.alu_op),    32'(h.op));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".out_a"},     32'(bus.out_a),     32'(m_out.a));
    chk({tag, ".out_b"},     32'(bus.out_b),     32'(m_out.b));
    chk({tag, ".out_op"},    32'(bus.out_op),    32'(m_out.op));
    chk({tag, ".out_y"},     32'(bus.out_y),     32'(m_y));
    chk({tag, ".res_cnt"},   32'(bus.res_cnt),   32'(m_res));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(logic v, logic [AW-1:0] a, logic [AW-1:0] b, logic [OW-1:0] op);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  task automatic pulse_reset(string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, ".out_valid_now"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".count_now"},     32'(bus.count),     32'd0);
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    logic [15:0] r0;
    checks = 0;
    errors = 0;
    delivered.delete();
    model_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);

    // 1. reset held for two cycles
    step("rst");
    step("rst");
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.count",    32'(bus.count),    32'd0);
    #1 rst_n = 1'b1;

    // 2. single ADD 3+5 with out_ready high
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd3, 4'd5, OP_ADD);
    step("s2");
    drive(1'b0, '0, '0, '0);
    chk("s2.head_a", 32'(bus.alu_a), 32'd3);
    chk("s2.valid_n", 32'(bus.out_valid), 32'd0);
    step("s2");
    chk("s2.out_valid", 32'(bus.out_valid), 32'd1);
    chk("s2.out_y", 32'(bus.out_y), 32'd8);
    chk("s2.out_a", 32'(bus.out_a), 32'd3);
    chk("s2.out_b", 32'(bus.out_b), 32'd5);
    step("s2");
    chk("s2.res_cnt", 32'(bus.res_cnt), 32'd1);

    // 3. backpressure: six MULs, five fit (four queued plus the output slot)
    pulse_reset("s3rst");
    delivered.delete();
    bus.out_ready = 1'b0;
    acc = 0;
    drive(1'b1, 4'd1, 4'd9, OP_MUL);
    for (int i = 0; i < 20 && acc < 5; i++) begin
      step("s3");
      if (m_last_push) begin
        acc++;
        bus.in_a = 4'(acc + 1);
      end
    end
    chk("s3.accepted", 32'(acc), 32'd5);
    chk("s3.count", 32'(bus.count), 32'd4);
    chk("s3.in_ready", 32'(bus.in_ready), 32'd0);
    chk("s3.out_y", 32'(bus.out_y), 32'd9);
    for (int i = 0; i < 10; i++) begin
      step("s3hold");
      chk("s3hold.out_y", 32'(bus.out_y), 32'd9);
      chk("s3hold.out_a", 32'(bus.out_a), 32'd1);
    end

    // 4. drain in order
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30 && delivered.size() < 6; i++) begin
      step("s4");
      if (m_last_push) bus.in_valid = 1'b0;
    end
    chk("s4.ndeliv", 32'(delivered.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < delivered.size()) chk($sformatf("s4.y%0d", i), 32'(delivered[i]), 32'(9 * (i + 1)));
    end
    chk("s4.res_cnt", 32'(bus.res_cnt), 32'd6);
    chk("s4.count", 32'(bus.count), 32'd0);
    chk("s4.out_valid", 32'(bus.out_valid), 32'd0);

    // 5. simultaneous push and pop with count=2
    bus.out_ready = 1'b0;
    acc = 0;
    drive(1'b1, 4'd4, 4'd2, OP_SUB);
    for (int i = 0; i < 10 && acc < 3; i++) begin
      step("s5fill");
      if (m_last_push) acc++;
    end
    bus.in_valid = 1'b0;
    chk("s5.count2", 32'(bus.count), 32'd2);
    chk("s5.valid", 32'(bus.out_valid), 32'd1);
    r0 = bus.res_cnt;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd15, 4'd15, OP_AND);
    step("s5");
    chk("s5.count_same", 32'(bus.count), 32'd2);
    chk("s5.res_inc", 32'(bus.res_cnt), 32'(r0 + 16'd1));

    // 6. reset mid-operation with count=3 and a held result
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd7, 4'd1, OP_ADD);
    step("s6fill");
    bus.in_valid = 1'b0;
    chk("s6.count3", 32'(bus.count), 32'd3);
    chk("s6.valid", 32'(bus.out_valid), 32'd1);
    pulse_reset("s6rst");
    delivered.delete();
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd2, 4'd7, OP_ADD);
    step("s6");
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && delivered.size() < 1; i++) step("s6");
    chk("s6.ndeliv", 32'(delivered.size()), 32'd1);
    if (delivered.size() > 0) chk("s6.first_y", 32'(delivered[0]), 32'd9);
    chk("s6.res_cnt", 32'(bus.res_cnt), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step("rnd");
    end
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step("flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Operand-issue and result-capture stage that wraps the combinational 4-bit ALU.
- Upstream: valid/ready producer of (a, b, op) commands. Commands are buffered in a DEPTH-entry FIFO.
- The FIFO head drives the ALU operand inputs; the ALU result is captured into a registered, back-pressurable output stage.
- Turns the free-running ALU into a flow-controlled pipeline stage.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2
- AW, 4, operand width; matches ALU a/b
- OW, 2, opcode width; matches ALU op
- YW, 8, result width; matches ALU y

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command present
- in_ready  out  1  FIFO can accept
- in_a  in  AW  operand a
- in_b  in  AW  operand b
- in_op  in  OW  opcode
- alu_a  out  AW  to ALU a (FIFO head)
- alu_b  out  AW  to ALU b
- alu_op  out  OW  to ALU op
- alu_y  in  YW  ALU result, combinational from alu_a/alu_b/alu_op
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts
- out_a  out  AW  operand a of the held result
- out_b  out  AW  operand b of the held result
- out_op  out  OW  opcode of the held result
- out_y  out  YW  captured alu_y
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register
- res_cnt  out  16  results delivered, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; out_a/out_b/out_op/out_y=0; count=0; res_cnt=0.
  - FIFO pointers cleared; in_ready=1 after reset.
  - Takes effect immediately, including mid-transfer. Held results and queued commands are discarded.
- Push:
  - in_ready = (count < DEPTH), combinational from state only.
  - A command is written on the edge where in_valid & in_ready.
  - No write-through bypass when full: a full FIFO stalls input even if a pop occurs in the same cycle.
- ALU drive:
  - alu_a/alu_b/alu_op = FIFO head when count>0, else all zero.
  - Driven from registers/mux only; no combinational path from in_* to alu_*.
- Pop/capture:
  - load = (count>0) & (!out_valid | out_ready).
  - On load: head is popped; out_a/out_b/out_op take the head fields, out_y takes alu_y; out_valid=1.
  - If out_valid & out_ready & !load: out_valid goes to 0 and the out_* fields hold their last values.
  - While out_valid & !out_ready, all out_* fields are stable.
- Counters:
  - res_cnt increments on each out_valid & out_ready edge.
  - count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency:
  - Command accepted at edge N is visible at the head after N. With an empty pipe, out_valid rises after edge N+1.
  - Throughput is 1 result/cycle when out_ready stays high.
- Ordering: strict FIFO; results leave in acceptance order.
- Pointers wrap modulo DEPTH. Full: count==DEPTH. Empty: count==0.
- Opcode meaning is defined in the package and consumed by the ALU/bench only; this block is opcode-agnostic.

Decomposition:
- Package alu_pkg:
  - Constants AW, OW, YW.
  - alu_op_e enum: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_AND=3.
  - Packed struct alu_cmd_t {a, b, op}.
- Sub-module cmd_fifo: parameterised synchronous FIFO of alu_cmd_t with push/pop/count/full/empty.
- The top level instantiates cmd_fifo and holds the output register plus res_cnt.
- The ALU instance is external; it is wired alongside this block in the integration top.

Test Plan:
1. Reset check: rst_n=0 held 2 cycles -> in_ready=1, out_valid=0, count=0, res_cnt=0, alu_a/alu_b/alu_op=0.
2. Single command, out_ready=1: push a=3, b=5, op=OP_ADD at edge N -> out_valid=1 after edge N+1 with out_y=8, out_a=3, out_b=5; res_cnt=1 one edge later.
3. Backpressure, out_ready=0, DEPTH=4: push 6 commands, a=1..6, b=9, op=OP_MUL.
   - First 5 are accepted; out_valid=1 holding out_y=9; count=4; in_ready=0.
   - 6th command waits with in_valid high.
   - Outputs stay stable for 10 cycles.
4. Drain: from scenario 3, raise out_ready -> out_y sequence 9, 18, 27, 36, 45, 54, one per cycle, in order; res_cnt=6; count=0; out_valid=0.
5. Simultaneous push/pop, count=2, out_valid=1, out_ready=1, in_valid=1 -> count stays 2 and res_cnt increments by 1.
6. Reset mid-operation with count=3 and out_valid=1: pulse rst_n low between clock edges -> out_valid and count go to 0 immediately. After release, a new command a=2, b=7, op=OP_ADD yields out_y=9 with no stale result delivered first.
